// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier: one multiplier bit per clock, start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port (two's complement operands).
module seq_mult_shift_add #(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic             sgn;
    logic             accept;
    logic             last;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (count == LAST_COUNT) begin
                    state_next = DONE;
                    last       = 1'b1;
                end
            end
            DONE: begin
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef SEQ_MULT_SIGNED_EN
    logic sgn_q;

    always_ff @(posedge clk) begin
        if (rst)         sgn_q <= 1'b0;
        else if (accept) sgn_q <= signed_mode;
    end

    assign sgn = sgn_q;
`else
    assign sgn = 1'b0;
`endif

    // The extra top bit holds the carry (unsigned) or the true sign of the sum (signed),
    // so the right shift always brings in the correct bit.
    always_comb begin
        acc_ext = {sgn & acc[WIDTH-1], acc};
        m_ext   = {sgn & m[WIDTH-1], m};
        sum     = acc_ext;
        if (q[0]) sum = (sgn && last) ? acc_ext - m_ext : acc_ext + m_ext;
    end

    // NOTE: the datapath registers are few and ordinary flops, so all of them are reset;
    // non-blocking assignments keep every register reading pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            m       <= '0;
            q       <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= sum[WIDTH:1];
            q     <= {sum[0], q[WIDTH-1:1]};
            count <= count + CW'(1);
            if (last) product <= {sum[WIDTH:1], sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: stimulus pushes expected products and completion
// cycles; a negedge monitor pops and compares busy, done and product every cycle.
module tb_seq_mult_shift_add;

    localparam int W  = 6;
    localparam int PW = 2 * W;

    typedef struct {
        logic [PW-1:0] prod;
        int            acc_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
    logic          signed_mode;
`endif

    exp_t          sb[$];
    logic [PW-1:0] prod_model;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    seq_mult_shift_add #(.WIDTH(W)) u_dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy(busy),
        .done(done),
        .product(product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer multiplication, truncated to the product width.
    function automatic logic [PW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input bit s);
        int ix;
        int iy;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        return PW'(ix * iy);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_busy;
            bit exp_done;
            exp_done = (sb.size() > 0) && (cyc == sb[0].acc_cyc + W);
            exp_busy = (sb.size() > 0) && (cyc < sb[0].acc_cyc + W);
            if (exp_done) begin
                prod_model = sb[0].prod;
                void'(sb.pop_front());
            end
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("product", 32'(product), 32'(prod_model));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called in IDLE or DONE; the next edge accepts the operation.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        bit eff_s;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = s;
        eff_s       = s;
`else
        eff_s       = 1'b0;
`endif
        a     = x;
        b     = y;
        start = 1'b1;
        step(1);
        start = 1'b0;
        sb.push_back('{prod: model(x, y, eff_s), acc_cyc: cyc});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sb.delete();
        prod_model = '0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        prod_model = '0;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = 1'b0;
`endif
        step(1);
        mon_en = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // All-ones operands exercise the carry path.
        issue(6'd63, 6'd63, 1'b0);
        step(W + 1);

        // Starts during RUN cycles 2 and 4 must be ignored.
        issue(6'd5, 6'd7, 1'b0);
        step(1);
        a = 6'd1; b = 6'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(W - 4 + 1);

        // Reset in RUN cycle 3 aborts with no done pulse and clears product.
        issue(6'd9, 6'd9, 1'b0);
        step(2);
        do_reset();
        step(2);
        issue(6'd3, 6'd4, 1'b0);
        step(W + 1);

        // Back-to-back: new start accepted in the DONE cycle.
        issue(6'd2, 6'd3, 1'b0);
        step(W);
        issue(6'd10, 6'd10, 1'b0);
        step(W + 1);

`ifdef SEQ_MULT_SIGNED_EN
        issue(6'h20, 6'h20, 1'b1);
        step(W + 1);
        issue(6'h3F, 6'h01, 1'b1);
        step(W + 1);
        issue(6'h1F, 6'h20, 1'b1);
        step(W + 1);
        issue(6'h3F, 6'h01, 1'b0);
        step(W + 1);
`endif

        // Randomized operations with random back-to-back or idle gaps.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            bit           rs;
            rx = W'($urandom);
            ry = W'($urandom);
            if (i % 10 == 0) rx = '1;
            if (i % 10 == 5) ry = '1;
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            issue(rx, ry, rs);
            step(W);
            if ($urandom_range(1, 0) == 0) step($urandom_range(2, 1));
        end
        step(W + 3);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
